// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the Mini SRC datapath. It walks the fetch states
// T0..T2, dispatches on the IR opcode field in T3 and then steps through the
// execute states of each instruction class. It drives the bus and register
// strobes and the Gra/Grb/Grc/Rin/Rout/BAout/Cout group used by the
// register-select/encode logic.
//
// Memory reads (T1, L6) and writes (S7) wait on mem_ready, so they can stall
// for any number of cycles.
//
// Ports
//   clock      : system clock, rising-edge active
//   clear      : asynchronous active-low reset, forces IDLE
//   start      : leaves IDLE for T0
//   stop       : sampled at each instruction boundary, high -> HALT
//   opcode     : IR[31:27], valid from T3 onward
//   con_ff     : branch condition flip-flop, decides PCin in B6
//   mem_ready  : memory completed the current Read/Write this cycle
//   PCout .. Cout  : bus drivers
//   PCin .. CONin  : register loads
//   Gra/Grb/Grc    : IR register-field selects
//   IncPC/Read/Write : PC increment and memory strobes
//   alu_op     : ALU operation, ADD unless an R/I-type op is executing
//   run        : high in every state except IDLE and HALT
// -----------------------------------------------------------------------------
module control_sequencer (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    input  logic       mem_ready,
    output logic       PCout,
    output logic       Zlowout,
    output logic       MDRout,
    output logic       Rout,
    output logic       BAout,
    output logic       Cout,
    output logic       PCin,
    output logic       IRin,
    output logic       MARin,
    output logic       MDRin,
    output logic       Yin,
    output logic       Zin,
    output logic       Rin,
    output logic       CONin,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       IncPC,
    output logic       Read,
    output logic       Write,
    output logic [4:0] alu_op,
    output logic       run
);

    // Opcodes the sequencer decodes
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [4:0] {
        ST_IDLE = 5'd0,
        ST_T0   = 5'd1,
        ST_T1   = 5'd2,
        ST_T2   = 5'd3,
        ST_T3   = 5'd4,
        ST_A4   = 5'd5,
        ST_A5   = 5'd6,
        ST_L6   = 5'd7,
        ST_L7   = 5'd8,
        ST_S6   = 5'd9,
        ST_S7   = 5'd10,
        ST_R4   = 5'd11,
        ST_R5   = 5'd12,
        ST_I4   = 5'd13,
        ST_I5   = 5'd14,
        ST_B4   = 5'd15,
        ST_B5   = 5'd16,
        ST_B6   = 5'd17,
        ST_HALT = 5'd18
    } state_t;

    // One bundle for every control output so decode and registering stay in step
    typedef struct packed {
        logic       pc_out;
        logic       zlow_out;
        logic       mdr_out;
        logic       r_out;
        logic       ba_out;
        logic       c_out;
        logic       pc_in;
        logic       ir_in;
        logic       mar_in;
        logic       mdr_in;
        logic       y_in;
        logic       z_in;
        logic       r_in;
        logic       con_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       inc_pc;
        logic       read;
        logic       write;
        logic       run;
        logic [4:0] alu_op;
    } ctl_t;

    localparam ctl_t CTL_IDLE = ctl_t'({21'd0, OP_ADD});

    state_t state_r;
    state_t next_state_s;
    ctl_t   ctl_r;
    ctl_t   ctl_s;
    ctl_t   t3_s;

    function automatic logic is_addr_f(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    function automatic logic is_rtype_f(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_itype_f(input logic [4:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    // Successor state; done_s is the instruction boundary where stop is honoured
    function automatic state_t next_state_f(
        input state_t     st,
        input logic       start_i,
        input logic       stop_i,
        input logic [4:0] op,
        input logic       rdy
    );
        state_t ns;
        state_t done_s;
        if (stop_i) begin
            done_s = ST_HALT;
        end else begin
            done_s = ST_T0;
        end
        case (st)
            ST_IDLE: begin
                if (start_i) ns = ST_T0;
                else         ns = ST_IDLE;
            end
            ST_T0: ns = ST_T1;
            ST_T1: begin
                if (rdy) ns = ST_T2;
                else     ns = ST_T1;
            end
            ST_T2: ns = ST_T3;
            ST_T3: begin
                if (is_addr_f(op))       ns = ST_A4;
                else if (is_rtype_f(op)) ns = ST_R4;
                else if (is_itype_f(op)) ns = ST_I4;
                else if (op == OP_BR)    ns = ST_B4;
                else if (op == OP_HALT)  ns = ST_HALT;
                else                     ns = done_s;   // jr, nop, unknown
            end
            ST_A4: ns = ST_A5;
            ST_A5: begin
                if (op == OP_LD)      ns = ST_L6;
                else if (op == OP_ST) ns = ST_S6;
                else                  ns = done_s;      // ldi finishes here
            end
            ST_L6: begin
                if (rdy) ns = ST_L7;
                else     ns = ST_L6;
            end
            ST_L7: ns = done_s;
            ST_S6: ns = ST_S7;
            ST_S7: begin
                if (rdy) ns = done_s;
                else     ns = ST_S7;
            end
            ST_R4:   ns = ST_R5;
            ST_R5:   ns = done_s;
            ST_I4:   ns = ST_I5;
            ST_I5:   ns = done_s;
            ST_B4:   ns = ST_B5;
            ST_B5:   ns = ST_B6;
            ST_B6:   ns = done_s;
            ST_HALT: ns = ST_HALT;
            default: ns = ST_IDLE;
        endcase
        return ns;
    endfunction

    // Strobes for the state being entered; loaded into ctl_r on the same edge
    // as the state so every output except the T3 group comes from a flop.
    function automatic ctl_t reg_decode_f(
        input state_t     ns,
        input state_t     st,
        input logic [4:0] op,
        input logic       cff
    );
        ctl_t c;
        c        = CTL_IDLE;
        c.run    = (ns != ST_IDLE) && (ns != ST_HALT);
        case (ns)
            ST_T0: begin
                c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
            end
            ST_T1: begin
                c.zlow_out = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
                // PC is loaded once; the wait cycles must not reload it
                c.pc_in    = (st != ST_T1);
            end
            ST_T2: begin
                c.mdr_out = 1'b1; c.ir_in = 1'b1;
            end
            ST_A4: begin
                c.c_out = 1'b1; c.z_in = 1'b1;
            end
            ST_A5: begin
                c.zlow_out = 1'b1;
                if (op == OP_LDI) begin
                    c.gra = 1'b1; c.r_in = 1'b1;
                end else begin
                    c.mar_in = 1'b1;
                end
            end
            ST_L6: begin
                c.read = 1'b1; c.mdr_in = 1'b1;
            end
            ST_L7: begin
                c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
            end
            ST_S6: begin
                c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
            end
            ST_S7: begin
                c.write = 1'b1;
            end
            ST_R4: begin
                c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = op;
            end
            ST_I4: begin
                c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = op;
            end
            ST_R5, ST_I5: begin
                c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
            end
            ST_B4: begin
                c.pc_out = 1'b1; c.y_in = 1'b1;
            end
            ST_B5: begin
                c.c_out = 1'b1; c.z_in = 1'b1;
            end
            ST_B6: begin
                c.zlow_out = 1'b1; c.pc_in = cff;
            end
            default: begin
                c.alu_op = OP_ADD;    // IDLE, T3, HALT: nothing beyond run
            end
        endcase
        return c;
    endfunction

    // T3 strobes depend on the freshly loaded IR, so they are decoded from the
    // opcode field (the controller's extended state) while in T3.
    function automatic ctl_t t3_decode_f(input logic [4:0] op);
        ctl_t c;
        c = ctl_t'(26'd0);
        if (is_addr_f(op)) begin
            c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
        end else if (is_rtype_f(op) || is_itype_f(op)) begin
            c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
        end else if (op == OP_BR) begin
            c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
        end else if (op == OP_JR_F()) begin
            c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
        end else begin
            c = ctl_t'(26'd0);
        end
        return c;
    endfunction

    function automatic logic [4:0] OP_JR_F();
        return 5'b10100;
    endfunction

    // Next-state selection
    always_comb begin
        next_state_s = next_state_f(state_r, start, stop, opcode, mem_ready);
    end

    // State and registered strobes; clear drops everything immediately
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r <= ST_IDLE;
            ctl_r   <= CTL_IDLE;
        end else begin
            state_r <= next_state_s;
            ctl_r   <= reg_decode_f(next_state_s, state_r, opcode, con_ff);
        end
    end

    // Merge the opcode-decoded T3 group onto the registered strobes
    always_comb begin
        t3_s = t3_decode_f(opcode);
        if (state_r == ST_T3) begin
            ctl_s = ctl_t'(ctl_r | t3_s);
        end else begin
            ctl_s = ctl_r;
        end
    end

    assign PCout   = ctl_s.pc_out;
    assign Zlowout = ctl_s.zlow_out;
    assign MDRout  = ctl_s.mdr_out;
    assign Rout    = ctl_s.r_out;
    assign BAout   = ctl_s.ba_out;
    assign Cout    = ctl_s.c_out;
    assign PCin    = ctl_s.pc_in;
    assign IRin    = ctl_s.ir_in;
    assign MARin   = ctl_s.mar_in;
    assign MDRin   = ctl_s.mdr_in;
    assign Yin     = ctl_s.y_in;
    assign Zin     = ctl_s.z_in;
    assign Rin     = ctl_s.r_in;
    assign CONin   = ctl_s.con_in;
    assign Gra     = ctl_s.gra;
    assign Grb     = ctl_s.grb;
    assign Grc     = ctl_s.grc;
    assign IncPC   = ctl_s.inc_pc;
    assign Read    = ctl_s.read;
    assign Write   = ctl_s.write;
    assign alu_op  = ctl_s.alu_op;
    assign run     = ctl_s.run;

endmodule
